// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: default sizes, AddRoundKey FSM encoding, width helper.
package aes_pkg;

  localparam int unsigned WORD_SIZE_DEF  = 8;
  localparam int unsigned ARRAY_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    ARK_IDLE = 2'd0,
    ARK_RUN  = 2'd1,
    ARK_DONE = 2'd2
  } ark_state_e;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ark_lane_xor.sv
// Combinational LANES-word XOR slice used by the sequential AddRoundKey engine.
module ark_lane_xor #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned LANES     = 4
) (
  input  logic [WORD_SIZE*LANES-1:0] a,
  input  logic [WORD_SIZE*LANES-1:0] b,
  output logic [WORD_SIZE*LANES-1:0] y
);

  // Plain bitwise XOR; no field reduction is needed for AddRoundKey.
  always_comb begin
    y = a ^ b;
  end

endmodule

// File: rtl/add_round_key_seq.sv
// Sequential AddRoundKey: accepts a state/key pair, XORs LANES words per beat,
// then holds the result until downstream accepts it.
module add_round_key_seq
  import aes_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
  parameter int unsigned ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int unsigned LANES      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_SIZE*ARRAY_SIZE-1:0]  state,
  input  logic [WORD_SIZE*ARRAY_SIZE-1:0]  key,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_SIZE*ARRAY_SIZE-1:0]  state_out,
  output logic                             busy
);

  localparam int unsigned STATE_W = WORD_SIZE * ARRAY_SIZE;
  localparam int unsigned SLICE_W = WORD_SIZE * LANES;
  localparam int unsigned BEATS   = ARRAY_SIZE / LANES;
  localparam int unsigned BEAT_W  = clog2_min1(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if ((ARRAY_SIZE % LANES) != 0) begin : g_bad_lanes
    $fatal(1, "add_round_key_seq: LANES must divide ARRAY_SIZE");
  end

  ark_state_e          fsm_q, fsm_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [STATE_W-1:0]  work_q, work_d;
  logic [STATE_W-1:0]  key_q, key_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [SLICE_W-1:0]  slice_work, slice_key, slice_xor;

  // Beat-indexed mux selecting the slice to combine this cycle.
  always_comb begin
    slice_work = '0;
    slice_key  = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        slice_work = work_q[b*SLICE_W +: SLICE_W];
        slice_key  = key_q[b*SLICE_W +: SLICE_W];
      end
    end
  end

  ark_lane_xor #(
    .WORD_SIZE (WORD_SIZE),
    .LANES     (LANES)
  ) u_lane_xor (
    .a (slice_work),
    .b (slice_key),
    .y (slice_xor)
  );

  // Next-state, datapath update and handshake decode.
  always_comb begin
    fsm_d    = fsm_q;
    beat_d   = beat_q;
    work_d   = work_q;
    key_d    = key_q;
    in_ready = 1'b0;
    case (fsm_q)
      ARK_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d = state;
          key_d  = key;
          beat_d = '0;
          fsm_d  = ARK_RUN;
        end
      end
      ARK_RUN: begin
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (beat_q == BEAT_W'(b)) begin
            work_d[b*SLICE_W +: SLICE_W] = slice_xor;
          end
        end
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          fsm_d  = ARK_DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ARK_DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            work_d = state;
            key_d  = key;
            beat_d = '0;
            fsm_d  = ARK_RUN;
          end else begin
            fsm_d = ARK_IDLE;
          end
        end
      end
      default: begin
        fsm_d  = ARK_IDLE;
        beat_d = '0;
      end
    endcase
    out_valid_d = (fsm_d == ARK_DONE);
    busy_d      = (fsm_d == ARK_RUN);
  end

  // State and datapath registers; reset discards any result in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= ARK_IDLE;
      beat_q      <= '0;
      work_q      <= '0;
      key_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      beat_q      <= beat_d;
      work_q      <= work_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign state_out = work_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_add_round_key_seq.sv
// Bench for add_round_key_seq: three instances (LANES 4, 16, 1) checked every
// cycle against a transaction-level model, plus directed FIPS-197 vectors.
module tb_add_round_key_seq;

  localparam int NI = 3;

  localparam logic [127:0] FIPS_S = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V2_S   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V2_K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V2_R   = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] V3_S   = 128'hdeadbeef0123456789abcdeffedcba98;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv   [NI];
  logic         ir   [NI];
  logic         ov   [NI];
  logic         ordy [NI];
  logic         bz   [NI];
  logic [127:0] st   [NI];
  logic [127:0] ky   [NI];
  logic [127:0] so   [NI];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LN = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    add_round_key_seq #(
      .WORD_SIZE  (8),
      .ARRAY_SIZE (16),
      .LANES      (LN)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .state     (st[g]),
      .key       (ky[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .state_out (so[g]),
      .busy      (bz[g])
    );
  end

  function automatic int beats_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 16);
  endfunction

  task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, i, act, exp);
    end
  endtask

  // Transaction model: a pair accepted now is ready BEATS edges later as state^key.
  int           m_cnt [NI];
  bit           m_vld [NI];
  logic [127:0] m_res [NI];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i] = 0;
        m_vld[i] = 1'b0;
        m_res[i] = '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit acc;
        acc = iv[i] && (m_cnt[i] == 0) && (!m_vld[i] || ordy[i]);
        if (m_vld[i] && ordy[i]) m_vld[i] = 1'b0;
        if (m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) m_vld[i] = 1'b1;
        end
        if (acc) begin
          m_res[i] = st[i] ^ ky[i];
          m_cnt[i] = beats_of(i);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        chk("out_valid", i, 128'(ov[i]), 128'(m_vld[i]));
        chk("busy", i, 128'(bz[i]), 128'(m_cnt[i] > 0));
        chk("in_ready", i, 128'(ir[i]), 128'((m_cnt[i] == 0) && (!m_vld[i] || ordy[i])));
        if (m_vld[i]) chk("state_out", i, so[i], m_res[i]);
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept one pair, wait for the result (bounded) and hand it off.
  task automatic run_vec(input int i, input logic [127:0] s, input logic [127:0] k,
                         input logic [127:0] exp, input string nm);
    int cnt;
    @(posedge clk); #1;
    ordy[i] = 1'b0; st[i] = s; ky[i] = k; iv[i] = 1'b1;
    chk({nm, "_ready"}, i, 128'(ir[i]), 128'd1);
    @(posedge clk); #1;
    iv[i] = 1'b0; st[i] = ~s; ky[i] = ~k;
    cnt = 0;
    while (!ov[i] && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({nm, "_latency"}, i, 128'(cnt), 128'(beats_of(i)));
    chk({nm, "_result"}, i, so[i], exp);
    ordy[i] = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_idle_valid"}, i, 128'(ov[i]), 128'd0);
    chk({nm, "_idle_ready"}, i, 128'(ir[i]), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n_acc, first_hi, second_hi;
    bit acc, b2b_acc;

    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; st[i] = '0; ky[i] = '0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_valid", i, 128'(ov[i]), 128'd0);
      chk("rst_busy", i, 128'(bz[i]), 128'd0);
      chk("rst_out", i, so[i], 128'd0);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) chk("rel_ready", i, 128'(ir[i]), 128'd1);

    // FIPS-197 round-0 vector on every lane configuration.
    run_vec(0, FIPS_S, FIPS_K, FIPS_R, "fips");
    run_vec(1, FIPS_S, FIPS_K, FIPS_R, "fips");
    run_vec(2, FIPS_S, FIPS_K, FIPS_R, "fips");
    run_vec(0, V2_S, V2_K, V2_R, "v2");

    // Backpressure: DONE held for 10 cycles while inputs churn.
    @(posedge clk); #1;
    ordy[0] = 1'b0; st[0] = FIPS_S; ky[0] = FIPS_K; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid", 0, 128'(ov[0]), 128'd1);
    for (int c = 0; c < 10; c++) begin
      st[0] = rnd128(); ky[0] = rnd128(); iv[0] = c[0];
      @(posedge clk); #1;
      chk("bp_hold", 0, so[0], FIPS_R);
      chk("bp_ready", 0, 128'(ir[0]), 128'd0);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", 0, 128'(ov[0]), 128'd0);
    chk("bp_rel_busy", 0, 128'(bz[0]), 128'd0);
    chk("bp_rel_ready", 0, 128'(ir[0]), 128'd1);

    // Back-to-back: second pair taken in the DONE cycle of the first.
    @(posedge clk); #1;
    ordy[0] = 1'b1; st[0] = FIPS_S; ky[0] = FIPS_K; iv[0] = 1'b1;
    n_acc = 0; first_hi = -1; second_hi = -1; b2b_acc = 1'b0;
    for (int c = 0; c < 40 && second_hi < 0; c++) begin
      acc = ir[0] && iv[0];
      if (ov[0]) begin
        if (first_hi < 0) begin
          first_hi = c;
          b2b_acc = acc;
          chk("b2b_first", 0, so[0], FIPS_R);
        end else begin
          second_hi = c;
          chk("b2b_second", 0, so[0], 128'd0);
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        if (n_acc == 1) begin
          st[0] = V3_S; ky[0] = V3_S;
        end else begin
          iv[0] = 1'b0;
        end
      end
    end
    iv[0] = 1'b0;
    chk("b2b_accepts", 0, 128'(n_acc), 128'd2);
    chk("b2b_accept_in_done", 0, 128'(b2b_acc), 128'd1);
    chk("b2b_gap", 0, 128'(second_hi - first_hi - 1), 128'd4);
    @(posedge clk); #1;

    // Reset asserted in the second RUN beat.
    st[0] = FIPS_S; ky[0] = FIPS_K; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 0, 128'(bz[0]), 128'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 0, 128'(ov[0]), 128'd0);
    chk("mid_rst_busy", 0, 128'(bz[0]), 128'd0);
    chk("mid_rst_out", 0, so[0], 128'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rel_ready", 0, 128'(ir[0]), 128'd1);
    run_vec(0, V2_S, V2_K, V2_R, "after_rst");

    // in_valid pulsed during RUN with different data must be ignored.
    @(posedge clk); #1;
    ordy[0] = 1'b0; st[0] = V2_S; ky[0] = V2_K; iv[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = FIPS_S; ky[0] = FIPS_K; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    cnt = 0;
    while (!ov[0] && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("ign_latency", 0, 128'(cnt), 128'd3);
    chk("ign_result", 0, so[0], V2_R);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("ign_idle", 0, 128'(ir[0]), 128'd1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
